// File: rtl/setup_serializer_if.sv
// Upstream byte handshake for setup_serializer.
// Handshake: a byte transfers on a rising clk_in edge where valid_in and
// ready_out are both 1. The master holds data_in stable while valid_in is high
// and not yet accepted. ready_out is registered and never depends on valid_in
// in the same cycle.
interface setup_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/setup_serializer.sv
// setup_serializer: feeds the 8-bit setup shift register of the FP adder.
// Accepts one byte over the cfg handshake, shifts it out LSB first with en_out
// high for DATA_W cycles, then holds en_out low for GAP_CYCLES idle cycles
// before it accepts the next byte.
// Optional build macro LOOPBACK_CHECK_EN adds a read-back compare of the
// register's parallel output against the byte that was sent.
// state_dbg exposes the FSM state (0 IDLE, 1 SHIFT, 2 GAP) for checkers.
module setup_serializer #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  setup_serializer_if.slave cfg,
  output logic              serial_out,
  output logic              en_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [1:0]        state_dbg
`ifdef LOOPBACK_CHECK_EN
  ,
  input  logic [DATA_W-1:0] parallel_in,
  output logic              check_valid_out,
  output logic              mismatch_out
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  // Gap counter is 4 bits wide for the 1..15 range; the last value is
  // computed once so GAP_CYCLES=1 ends the gap on its first cycle.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        gap_cnt;
  // The buffer rotates right rather than shifting, so the bit leaving the
  // bottom re-enters at the top; after DATA_W rotations it holds the
  // original byte again, which is what the loopback compare needs.
  logic [DATA_W-1:0] shift_buf;

  assign state_dbg = state;

  // Frame sequencer: handshake, bit shifting, gap timing and all outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      shift_buf     <= '0;
      serial_out    <= 1'b1;
      en_out        <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      cfg.ready_out <= 1'b1;
`ifdef LOOPBACK_CHECK_EN
      check_valid_out <= 1'b0;
      mismatch_out    <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
      check_valid_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg.valid_in && cfg.ready_out) begin
            state         <= SHIFT;
            shift_buf     <= cfg.data_in;
            bit_cnt       <= '0;
            serial_out    <= cfg.data_in[0];
            en_out        <= 1'b1;
            busy_out      <= 1'b1;
            cfg.ready_out <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
            mismatch_out  <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          shift_buf <= {shift_buf[0], shift_buf[DATA_W-1:1]};
          if (bit_cnt == BIT_LAST) begin
            state      <= GAP;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            serial_out <= 1'b1;
            en_out     <= 1'b0;
            done_out   <= 1'b1;
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            serial_out <= shift_buf[1];
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            busy_out      <= 1'b0;
            cfg.ready_out <= 1'b1;
`ifdef LOOPBACK_CHECK_EN
            check_valid_out <= 1'b1;
            mismatch_out    <= (parallel_in != shift_buf);
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          serial_out    <= 1'b1;
          en_out        <= 1'b0;
          busy_out      <= 1'b0;
          cfg.ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setup_serializer.sv
// Testbench for setup_serializer: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a cycle-index model.
// Define LOOPBACK_CHECK_EN for both RTL and bench to cover the read-back port.
module tb_setup_serializer;
  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 2;
  localparam int FRAME      = 1 + DATA_W + GAP_CYCLES;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       serial, en, busy, done;
  logic [1:0] state_dbg;
  setup_serializer_if #(.DATA_W(DATA_W)) cfg_if ();

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Model of the downstream setup register: shifts in LSB first while en is high.
  logic [7:0] sr = 8'h00;
  always @(posedge clk) if (en) sr <= {serial, sr[7:1]};

`ifdef LOOPBACK_CHECK_EN
  logic       fault = 1'b0;
  logic [7:0] parallel;
  logic       chk, mis;
  // fault models a read-back path with bit 3 stuck at 0.
  assign parallel = fault ? (sr & 8'hF7) : sr;
`endif

  setup_serializer #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .cfg        (cfg_if),
    .serial_out (serial),
    .en_out     (en),
    .busy_out   (busy),
    .done_out   (done),
    .state_dbg  (state_dbg)
`ifdef LOOPBACK_CHECK_EN
    ,
    .parallel_in     (parallel),
    .check_valid_out (chk),
    .mismatch_out    (mis)
`endif
  );

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int c;
    c = 0;
    while (cfg_if.ready_out !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    check("ready_timeout", 32'(cfg_if.ready_out), 32'(1));
  endtask

  // Sends one byte and records what the serial side showed over the frame.
  task automatic send_frame(input logic [7:0] data, output logic [7:0] word,
                            output int en_cnt, output int done_cnt,
                            output int bad_idle, output int first_en);
    word = 8'h00; en_cnt = 0; done_cnt = 0; bad_idle = 0; first_en = -1;
    wait_ready(40);
    cfg_if.data_in  = data;
    cfg_if.valid_in = 1'b1;
    step();
    cfg_if.valid_in = 1'b0;
    for (int i = 0; i < FRAME + 1; i++) begin
      if (en === 1'b1) begin
        if (first_en < 0) first_en = i;
        if (en_cnt < 8) word[en_cnt] = serial;
        en_cnt++;
      end else if (serial !== 1'b1) begin
        bad_idle++;
      end
      if (done === 1'b1) done_cnt++;
      step();
    end
  endtask

`ifdef LOOPBACK_CHECK_EN
  task automatic loop_frame(input logic [7:0] data, input logic exp_mis);
    wait_ready(40);
    cfg_if.data_in  = data;
    cfg_if.valid_in = 1'b1;
    step();
    cfg_if.valid_in = 1'b0;
    check("mis_clear_on_accept", 32'(mis), 32'(0));
    repeat (DATA_W + GAP_CYCLES) step();
    check("chk_pulse", 32'(chk), 32'(1));
    check("mis_value", 32'(mis), 32'(exp_mis));
    step();
    check("chk_one_cycle", 32'(chk), 32'(0));
    check("mis_hold", 32'(mis), 32'(exp_mis));
    step();
    check("mis_hold2", 32'(mis), 32'(exp_mis));
  endtask
`endif

  // ---------------- scoreboard ----------------
  // Every done pulse must match the next expected byte in the setup register.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'(0));
      else check("setup_reg", 32'(sr), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_word;
    int         exp_en;
    int         exp_ones;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [7:0] word;
    int en_cnt, done_cnt, bad, first_en;
    int first_acc, second_acc, low_cnt, m, free_at, acc, k;
    logic [7:0] abyte, rbyte, seq;
    logic [4:0] exp_vec;
    logic take, v, exp_mis;

    vecs[0] = '{8'hAA, 8'hAA, 8, 4};
    vecs[1] = '{8'h00, 8'h00, 8, 0};
    vecs[2] = '{8'hFF, 8'hFF, 8, 8};
    vecs[3] = '{8'h12, 8'h12, 8, 2};
    vecs[4] = '{8'hCD, 8'hCD, 8, 5};
    vecs[5] = '{8'h3C, 8'h3C, 8, 4};
    vecs[6] = '{8'h81, 8'h81, 8, 2};

    cfg_if.valid_in = 1'b0;
    cfg_if.data_in  = 8'h00;

    // Reset state
    repeat (3) step();
    check("rst_outputs", 32'({cfg_if.ready_out, busy, en, serial, done}), 32'(5'b10010));
    check("rst_state", 32'(state_dbg), 32'(0));
    #3 rst_n = 1'b1;
    step();
    check("idle_after_rst", 32'({cfg_if.ready_out, busy, en, serial, done}), 32'(5'b10010));

    // Directed vector table: one frame each
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, word, en_cnt, done_cnt, bad, first_en);
      check("serial_word", 32'(word), 32'(vecs[i].exp_word));
      check("en_cycles", 32'(en_cnt), 32'(vecs[i].exp_en));
      check("ones_count", 32'($countones(word)), 32'(vecs[i].exp_ones));
      check("done_count", 32'(done_cnt), 32'(1));
      check("serial_idle_high", 32'(bad), 32'(0));
      check("en_first_cycle", 32'(first_en), 32'(0));
    end

    // Back-to-back 0x12 then 0xCD with valid held high
    wait_ready(40);
    first_acc = -1; second_acc = -1; low_cnt = 0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hCD);
    cfg_if.data_in  = 8'h12;
    cfg_if.valid_in = 1'b1;
    for (int i = 0; i < 40 && second_acc < 0; i++) begin
      if (cfg_if.ready_out === 1'b1) begin
        if (first_acc < 0) first_acc = i;
        else second_acc = i;
      end
      step();
      if (second_acc >= 0) cfg_if.valid_in = 1'b0;
      if (first_acc >= 0) cfg_if.data_in = 8'hCD;
      if (first_acc >= 0 && second_acc < 0 && cfg_if.ready_out === 1'b0) low_cnt++;
    end
    cfg_if.valid_in = 1'b0;
    check("b2b_spacing", 32'(second_acc - first_acc), 32'(11));
    check("b2b_ready_low", 32'(low_cnt), 32'(10));
    repeat (FRAME) step();

    // valid/data wiggle while busy sending 0x3C
    wait_ready(40);
    exp_q.push_back(8'h3C);
    cfg_if.data_in  = 8'h3C;
    cfg_if.valid_in = 1'b1;
    step();
    cfg_if.data_in = 8'h55;
    seq = 8'h00; low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) seq[i] = serial;
      if (cfg_if.ready_out === 1'b0) low_cnt++;
      step();
    end
    check("busy_ignores_valid", 32'(low_cnt), 32'(10));
    check("busy_frame_bits", 32'(seq), 32'(8'h3C));
    exp_q.push_back(8'h55);
    check("ready_after_gap", 32'(cfg_if.ready_out), 32'(1));
    step();
    cfg_if.valid_in = 1'b0;
    check("accept_55_en", 32'(en), 32'(1));
    repeat (FRAME) step();

    // Reset at SHIFT cycle 4 of 0xF0
    wait_ready(40);
    cfg_if.data_in  = 8'hF0;
    cfg_if.valid_in = 1'b1;
    step();
    cfg_if.valid_in = 1'b0;
    repeat (4) step();
    check("pre_rst_en", 32'(en), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({cfg_if.ready_out, busy, en, serial, done}), 32'(5'b10010));
    check("async_rst_state", 32'(state_dbg), 32'(0));
    step();
    step();
    #3 rst_n = 1'b1;
    repeat (FRAME) step();
    check("post_rst_ready", 32'(cfg_if.ready_out), 32'(1));
    exp_q.push_back(8'h81);
    send_frame(8'h81, word, en_cnt, done_cnt, bad, first_en);
    check("post_rst_word", 32'(word), 32'(8'h81));
    check("post_rst_done", 32'(done_cnt), 32'(1));

`ifdef LOOPBACK_CHECK_EN
    // Correct read-back, then bit 3 stuck at 0 with a byte whose bit 3 is 1
    // (0xA5 has bit 3 clear, so it cannot expose that fault), then a clean
    // frame whose accept clears the held mismatch.
    fault = 1'b0;
    exp_q.push_back(8'hA5);
    loop_frame(8'hA5, 1'b0);
    fault = 1'b1;
    exp_q.push_back(8'h5A);
    loop_frame(8'h5A, 1'b1);
    fault = 1'b0;
    exp_q.push_back(8'hA5);
    loop_frame(8'hA5, 1'b0);
`endif

    // Randomized traffic against the cycle-index model
    cfg_if.valid_in = 1'b0;
    wait_ready(40);
    step();
    step();
`ifdef LOOPBACK_CHECK_EN
    fault = 1'($urandom_range(0, 1));
`endif
    m = 0; free_at = 0; acc = -100; abyte = 8'h00; exp_mis = 1'b0;
    for (int it = 0; it < 400; it++) begin
      v     = ($urandom_range(0, 3) != 0);
      rbyte = 8'($urandom_range(0, 255));
      cfg_if.valid_in = v;
      cfg_if.data_in  = rbyte;
      take = v && (m >= free_at);
      step();
      m++;
      if (take) begin
        acc     = m;
        abyte   = rbyte;
        free_at = m + DATA_W + GAP_CYCLES;
        exp_q.push_back(rbyte);
        exp_mis = 1'b0;
      end
      k = m - acc;
      if (k < DATA_W) exp_vec = {1'b0, 1'b1, 1'b1, abyte[k], 1'b0};
      else if (k == DATA_W) exp_vec = 5'b01011;
      else if (k < DATA_W + GAP_CYCLES) exp_vec = 5'b01010;
      else exp_vec = 5'b10010;
      check("rand_outputs", 32'({cfg_if.ready_out, busy, en, serial, done}), 32'(exp_vec));
`ifdef LOOPBACK_CHECK_EN
      if (k == DATA_W + GAP_CYCLES) exp_mis = fault & abyte[3];
      check("rand_chk", 32'(chk), 32'(k == DATA_W + GAP_CYCLES));
      check("rand_mis", 32'(mis), 32'(exp_mis));
`endif
    end
    cfg_if.valid_in = 1'b0;
    wait_ready(40);
    step();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
